// File: rtl/mips_pipe_defs.sv
// rtl/mips_pipe_defs.sv - shared pipeline hazard state encodings and divide latency
package mips_pipe_defs;

  typedef enum logic {
    PH_RUN      = 1'b0,
    PH_DIV_WAIT = 1'b1
  } ph_state_t;

  localparam int DIV_CYCLES_DEF = 32;

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage F/D/E/M/W pipeline
module pipe_hazard_ctrl
  import mips_pipe_defs::*;
#(
  parameter int REG_W      = 5,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_memtoreg,
  input  logic             ex_div_start,
  input  logic             mem_stall,
  input  logic             mem_exc,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             pc_redirect,
  output logic             div_busy,
  output logic             div_done
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  ph_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             load_use;

  assign load_use = ex_memtoreg && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PH_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Priority: exception > SRAM wait > divide > load-use.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    flush_w     = 1'b0;
    pc_redirect = 1'b0;
    div_busy    = (state == PH_DIV_WAIT);
    div_done    = 1'b0;

    if (mem_exc) begin
      flush_d     = 1'b1;
      flush_e     = 1'b1;
      flush_m     = 1'b1;
      pc_redirect = 1'b1;
      state_n     = PH_RUN;
      cnt_n       = '0;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (state == PH_DIV_WAIT) begin
      if (cnt != '0) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
        cnt_n   = cnt - CNT_W'(1);
      end else begin
        div_done = 1'b1;
        state_n  = PH_RUN;
      end
    end else if (ex_div_start) begin
      // The start cycle is itself a stall, so the wait counts DIV_CYCLES-2 down to 0.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
      cnt_n   = CNT_W'(DIV_CYCLES - 2);
      state_n = PH_DIV_WAIT;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table and sequence checks of pipe_hazard_ctrl with a scoreboard
module tb_pipe_hazard_ctrl;

  localparam logic [10:0] SF = 11'h400, SD = 11'h200, SE = 11'h100, SM = 11'h080;
  localparam logic [10:0] FD = 11'h040, FE = 11'h020, FM = 11'h010, FW = 11'h008;
  localparam logic [10:0] PC = 11'h004, BZ = 11'h002, DN = 11'h001;
  localparam logic [10:0] LU   = SF | SD | FE;
  localparam logic [10:0] MS   = SF | SD | SE | SM | FW;
  localparam logic [10:0] EXC  = FD | FE | FM | PC;
  localparam logic [10:0] DIVS = SF | SD | SE | FM;
  localparam logic [10:0] DIVW = DIVS | BZ;
  localparam logic [10:0] DONE = BZ | DN;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memtoreg, ex_div_start, mem_stall, mem_exc;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, flush_w;
  logic       pc_redirect, div_busy, div_done;
  logic [10:0] outv;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [10:0] exp;
    string       name;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [4:0]  rs, rt, ert;
    logic        ld, dv, ms, ex;
    logic [10:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_memtoreg(ex_memtoreg), .ex_div_start(ex_div_start),
    .mem_stall(mem_stall), .mem_exc(mem_exc),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .pc_redirect(pc_redirect), .div_busy(div_busy), .div_done(div_done)
  );

  assign outv = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
                 pc_redirect, div_busy, div_done};

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                       input logic ld, input logic dv, input logic ms, input logic ex);
    id_rs = rs; id_rt = rt; ex_rt = ert;
    ex_memtoreg = ld; ex_div_start = dv; mem_stall = ms; mem_exc = ex;
  endtask

  // Inputs are already driven; queue the expectation, compare mid-cycle, advance one clock.
  task automatic step(input logic [10:0] exp, input string name);
    sb_t e;
    sbq.push_back('{exp, name});
    @(negedge clk);
    e = sbq.pop_front();
    n_checks++;
    if (outv === e.exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", e.name, outv, e.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [10:0] exp, input string name);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(exp, name);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 11'h000, "idle"});
    vecs.push_back('{5'd5, 5'd1, 5'd5, 1, 0, 0, 0, LU,      "lu_rs"});
    vecs.push_back('{5'd2, 5'd9, 5'd9, 1, 0, 0, 0, LU,      "lu_rt"});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 11'h000, "lu_r0"});
    vecs.push_back('{5'd3, 5'd4, 5'd5, 1, 0, 0, 0, 11'h000, "lu_nomatch"});
    vecs.push_back('{5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 11'h000, "match_noload"});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MS,      "mem_stall"});
    vecs.push_back('{5'd5, 5'd0, 5'd5, 1, 0, 1, 0, MS,      "ms_over_lu"});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, EXC,     "mem_exc"});
    vecs.push_back('{5'd5, 5'd5, 5'd5, 1, 0, 1, 1, EXC,     "exc_over_all"});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 1, 1, 0, MS,      "ms_blocks_div"});
    vecs.push_back('{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 11'h000, "div_not_started"});

    do_reset();
    idle(11'h000, "reset_state");

    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].ert, vecs[i].ld, vecs[i].dv, vecs[i].ms, vecs[i].ex);
      step(vecs[i].exp, vecs[i].name);
    end

    // Load-use: exactly one bubble, then the load has moved on to M.
    drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step(LU, "lu_bubble");
    idle(11'h000, "lu_cleared");

    // Full divide: 31 stall cycles, done on cycle 32; a load-use inside the wait adds nothing.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(DIVS, "div_start");
    for (int k = 1; k <= 30; k++) begin
      if (k == 12) drive(5'd7, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      else         drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(DIVW, (k == 12) ? "div_wait_lu" : "div_wait");
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(DONE, "div_done");
    idle(11'h000, "div_back_run");

    // mem_stall for 3 cycles while the wait counter sits at 10.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(DIVS, "div2_start");
    for (int k = 1; k <= 20; k++) step(DIVW, "div2_wait_pre");
    for (int k = 0; k < 3; k++) begin
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      step(MS | BZ, "div2_mem_stall");
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) step(DIVW, "div2_wait_post");
    step(DONE, "div2_done");
    idle(11'h000, "div2_back_run");

    // Exception at count 7 aborts the divide; div_done must never follow.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(DIVS, "div3_start");
    for (int k = 1; k <= 23; k++) step(DIVW, "div3_wait");
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(EXC | BZ, "div3_exc");
    for (int k = 0; k < 10; k++) idle(11'h000, "div3_aborted");

    // Reset during the divide wait.
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(DIVS, "div4_start");
    for (int k = 1; k <= 5; k++) step(DIVW, "div4_wait");
    do_reset();
    idle(11'h000, "rst_in_div");
    idle(11'h000, "rst_in_div_stays");

    if (sbq.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sbq.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
